// File: rtl/somador_pkg.sv
// Shared types and default widths for the checkout accumulator.
package somador_pkg;

  typedef enum logic [1:0] {
    ACUM  = 2'd0,
    FECHO = 2'd1,
    TALAO = 2'd2
  } estado_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_CLR  = 2'd3
  } acc_op_t;

  localparam int PRICE_W_DEF   = 11;
  localparam int WEIGHT_W_DEF  = 11;
  localparam int SUM_W_DEF     = 16;
  localparam int CNT_W_DEF     = 8;
  localparam int MAX_ITEMS_DEF = 255;
  localparam int TAX_W_DEF     = 5;
  localparam int TAX_VALUE_DEF = 5;

endpackage

// File: rtl/somador_compra_param_if.sv
// Item/receipt bus between the scale front-end, the accumulator and the receipt emitter.
interface somador_compra_param_if
  import somador_pkg::*;
#(
  parameter int PRICE_W  = PRICE_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int SUM_W    = SUM_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TAX_W    = TAX_W_DEF
);
  logic                item_valid;
  logic                item_ready;
  logic [PRICE_W-1:0]  preco_produto;
  logic [WEIGHT_W-1:0] peso_produto;
  logic                estorno;
  logic                taxa;
  logic                fim_compra;
  logic                talao_ready;
  logic [SUM_W-1:0]    soma_final;
  logic [SUM_W-1:0]    soma_peso;
  logic [CNT_W-1:0]    n_itens;
  logic [TAX_W-1:0]    valor_taxa;
  logic                emissao_talao;
  logic                overflow;
  logic                ocupado;

  modport master (
    output item_valid, preco_produto, peso_produto, estorno, taxa, fim_compra, talao_ready,
    input  item_ready, soma_final, soma_peso, n_itens, valor_taxa, emissao_talao, overflow, ocupado
  );

  modport slave (
    input  item_valid, preco_produto, peso_produto, estorno, taxa, fim_compra, talao_ready,
    output item_ready, soma_final, soma_peso, n_itens, valor_taxa, emissao_talao, overflow, ocupado
  );
endinterface

// File: rtl/acumulador_sat.sv
// Saturating accumulator register: add (clamps at all-ones), subtract (floors at 0), clear.
// sat is a same-cycle flag raised when an add clamps.
module acumulador_sat
  import somador_pkg::*;
#(
  parameter int W = SUM_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  acc_op_t      op,
  input  logic [W-1:0] operando,
  output logic [W-1:0] valor,
  output logic         sat
);
  logic [W-1:0] valor_q, valor_d;
  logic [W:0]   soma_s;

  always_comb begin
    soma_s  = {1'b0, valor_q} + {1'b0, operando};
    valor_d = valor_q;
    sat     = 1'b0;
    case (op)
      OP_ADD: begin
        if (soma_s[W]) begin
          valor_d = '1;
          sat     = 1'b1;
        end else begin
          valor_d = soma_s[W-1:0];
        end
      end
      OP_SUB: begin
        if (operando > valor_q) begin
          valor_d = '0;
        end else begin
          valor_d = valor_q - operando;
        end
      end
      OP_CLR:  valor_d = '0;
      default: valor_d = valor_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valor_q <= '0;
    else     valor_q <= valor_d;
  end

  assign valor = valor_q;
endmodule

// File: rtl/somador_compra_param.sv
// Checkout accumulator: sums accepted items, supports one-level void and a fixed fee,
// then holds the closed totals for the receipt emitter until it handshakes.
module somador_compra_param
  import somador_pkg::*;
#(
  parameter int PRICE_W   = PRICE_W_DEF,
  parameter int WEIGHT_W  = WEIGHT_W_DEF,
  parameter int SUM_W     = SUM_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_ITEMS = MAX_ITEMS_DEF,
  parameter int TAX_W     = TAX_W_DEF,
  parameter int TAX_VALUE = TAX_VALUE_DEF
) (
  input logic clk,
  input logic rst,
  somador_compra_param_if.slave bus
);
  estado_t             estado_q, estado_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                taxa_q, taxa_d;
  logic                last_valid_q, last_valid_d;
  logic [PRICE_W-1:0]  last_preco_q, last_preco_d;
  logic [WEIGHT_W-1:0] last_peso_q, last_peso_d;
  logic [TAX_W-1:0]    valor_taxa_q, valor_taxa_d;
  logic                emissao_q, emissao_d;
  logic                ocupado_q, ocupado_d;

  acc_op_t          op_preco_s, op_peso_s;
  logic [SUM_W-1:0] opnd_preco_s, opnd_peso_s;
  logic [SUM_W-1:0] soma_preco_s, soma_peso_s;
  logic             sat_preco_s, sat_peso_s;
  logic             item_ready_s, aceita_s, estorno_ok_s, limpa_s;

  acumulador_sat #(.W(SUM_W)) u_acc_preco (
    .clk(clk), .rst(rst), .op(op_preco_s), .operando(opnd_preco_s),
    .valor(soma_preco_s), .sat(sat_preco_s)
  );

  acumulador_sat #(.W(SUM_W)) u_acc_peso (
    .clk(clk), .rst(rst), .op(op_peso_s), .operando(opnd_peso_s),
    .valor(soma_peso_s), .sat(sat_peso_s)
  );

  always_comb begin
    estado_d     = estado_q;
    cnt_d        = cnt_q;
    taxa_d       = taxa_q;
    last_valid_d = last_valid_q;
    last_preco_d = last_preco_q;
    last_peso_d  = last_peso_q;
    valor_taxa_d = valor_taxa_q;
    op_preco_s   = OP_NONE;
    op_peso_s    = OP_NONE;
    opnd_preco_s = '0;
    opnd_peso_s  = '0;
    item_ready_s = 1'b0;
    aceita_s     = 1'b0;
    estorno_ok_s = 1'b0;
    limpa_s      = 1'b0;
    case (estado_q)
      ACUM: begin
        item_ready_s = (cnt_q < CNT_W'(MAX_ITEMS)) && !bus.estorno;
        aceita_s     = bus.item_valid && item_ready_s;
        // A saturated sum cannot be undone exactly, so the void is refused once overflow is set.
        estorno_ok_s = bus.estorno && last_valid_q && !ovf_q;
        if (bus.taxa) taxa_d = 1'b1;
        else          taxa_d = taxa_q;
        if (estorno_ok_s) begin
          op_preco_s   = OP_SUB;
          op_peso_s    = OP_SUB;
          opnd_preco_s = SUM_W'(last_preco_q);
          opnd_peso_s  = SUM_W'(last_peso_q);
          cnt_d        = cnt_q - CNT_W'(1);
          last_valid_d = 1'b0;
        end else if (aceita_s) begin
          op_preco_s   = OP_ADD;
          op_peso_s    = OP_ADD;
          opnd_preco_s = SUM_W'(bus.preco_produto);
          opnd_peso_s  = SUM_W'(bus.peso_produto);
          cnt_d        = cnt_q + CNT_W'(1);
          last_preco_d = bus.preco_produto;
          last_peso_d  = bus.peso_produto;
          last_valid_d = 1'b1;
        end else begin
          op_preco_s = OP_NONE;
          op_peso_s  = OP_NONE;
        end
        if (bus.fim_compra && ((cnt_q != '0) || aceita_s)) estado_d = FECHO;
        else                                               estado_d = ACUM;
      end
      FECHO: begin
        // The fee is folded into the price accumulator so soma_final carries the total in TALAO.
        op_preco_s   = OP_ADD;
        opnd_preco_s = taxa_q ? SUM_W'(TAX_VALUE) : '0;
        valor_taxa_d = taxa_q ? TAX_W'(TAX_VALUE) : '0;
        estado_d     = TALAO;
      end
      TALAO: begin
        if (bus.talao_ready) begin
          limpa_s      = 1'b1;
          op_preco_s   = OP_CLR;
          op_peso_s    = OP_CLR;
          cnt_d        = '0;
          valor_taxa_d = '0;
          taxa_d       = 1'b0;
          last_valid_d = 1'b0;
          estado_d     = ACUM;
        end else begin
          estado_d = TALAO;
        end
      end
      default: estado_d = ACUM;
    endcase
    emissao_d = (estado_d == TALAO);
    ocupado_d = (estado_d != ACUM);
  end

  always_comb begin
    if (limpa_s) ovf_d = 1'b0;
    else         ovf_d = ovf_q | sat_preco_s | sat_peso_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q     <= ACUM;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      taxa_q       <= 1'b0;
      last_valid_q <= 1'b0;
      last_preco_q <= '0;
      last_peso_q  <= '0;
      valor_taxa_q <= '0;
      emissao_q    <= 1'b0;
      ocupado_q    <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      taxa_q       <= taxa_d;
      last_valid_q <= last_valid_d;
      last_preco_q <= last_preco_d;
      last_peso_q  <= last_peso_d;
      valor_taxa_q <= valor_taxa_d;
      emissao_q    <= emissao_d;
      ocupado_q    <= ocupado_d;
    end
  end

  assign bus.item_ready    = item_ready_s;
  assign bus.soma_final    = soma_preco_s;
  assign bus.soma_peso     = soma_peso_s;
  assign bus.n_itens       = cnt_q;
  assign bus.valor_taxa    = valor_taxa_q;
  assign bus.emissao_talao = emissao_q;
  assign bus.overflow      = ovf_q;
  assign bus.ocupado       = ocupado_q;
endmodule

// File: tb/tb_somador_compra_param.sv
// Drives identical stimulus into a 16-bit-sum and a 12-bit-sum instance and checks both
// against a purchase-level reference model every cycle, plus literal expectations.
module tb_somador_compra_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int last_rdy[2];

  somador_compra_param_if #(.SUM_W(16)) bus0 ();
  somador_compra_param_if #(.SUM_W(12)) bus1 ();

  somador_compra_param #(.SUM_W(16)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  somador_compra_param #(.SUM_W(12)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Reference model: one purchase per instance, phase 0 = buying, 1 = closing, 2 = receipt shown.
  int m_sp[2], m_sw[2], m_n[2], m_ovf[2], m_tax[2], m_lv[2], m_lp[2], m_lw[2], m_fee[2], m_ph[2];
  int maxv[2] = '{65535, 4095};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sp[i] = 0; m_sw[i] = 0; m_n[i] = 0; m_ovf[i] = 0; m_tax[i] = 0;
      m_lv[i] = 0; m_lp[i] = 0; m_lw[i] = 0; m_fee[i] = 0; m_ph[i] = 0;
    end
  endtask

  function automatic int m_ready(input int i, input int est);
    return (m_ph[i] == 0 && m_n[i] < 255 && est == 0) ? 1 : 0;
  endfunction

  task automatic model_step(input int i, input int iv, input int pp, input int pw,
                            input int est, input int tx, input int fim, input int tr);
    int acc, n0, fee;
    n0  = m_n[i];
    acc = (iv != 0 && m_ready(i, est) != 0) ? 1 : 0;
    if (m_ph[i] == 0) begin
      if (tx != 0) m_tax[i] = 1;
      if (est != 0 && m_lv[i] != 0 && m_ovf[i] == 0) begin
        m_sp[i] = (m_sp[i] > m_lp[i]) ? m_sp[i] - m_lp[i] : 0;
        m_sw[i] = (m_sw[i] > m_lw[i]) ? m_sw[i] - m_lw[i] : 0;
        m_n[i]--;
        m_lv[i] = 0;
      end else if (acc != 0) begin
        if (m_sp[i] + pp > maxv[i]) begin m_sp[i] = maxv[i]; m_ovf[i] = 1; end
        else m_sp[i] += pp;
        if (m_sw[i] + pw > maxv[i]) begin m_sw[i] = maxv[i]; m_ovf[i] = 1; end
        else m_sw[i] += pw;
        m_n[i]++;
        m_lp[i] = pp; m_lw[i] = pw; m_lv[i] = 1;
      end
      if (fim != 0 && (n0 != 0 || acc != 0)) m_ph[i] = 1;
    end else if (m_ph[i] == 1) begin
      fee = (m_tax[i] != 0) ? 5 : 0;
      if (m_sp[i] + fee > maxv[i]) begin m_sp[i] = maxv[i]; m_ovf[i] = 1; end
      else m_sp[i] += fee;
      m_fee[i] = fee;
      m_ph[i]  = 2;
    end else if (tr != 0) begin
      m_sp[i] = 0; m_sw[i] = 0; m_n[i] = 0; m_ovf[i] = 0; m_tax[i] = 0;
      m_lv[i] = 0; m_fee[i] = 0; m_ph[i] = 0;
    end
  endtask

  task automatic read_dut(input int i, output int sf, output int sp, output int n, output int vt,
                          output int em, output int ov, output int oc, output int rd);
    if (i == 0) begin
      sf = 32'(bus0.soma_final); sp = 32'(bus0.soma_peso); n = 32'(bus0.n_itens);
      vt = 32'(bus0.valor_taxa); em = 32'(bus0.emissao_talao); ov = 32'(bus0.overflow);
      oc = 32'(bus0.ocupado); rd = 32'(bus0.item_ready);
    end else begin
      sf = 32'(bus1.soma_final); sp = 32'(bus1.soma_peso); n = 32'(bus1.n_itens);
      vt = 32'(bus1.valor_taxa); em = 32'(bus1.emissao_talao); ov = 32'(bus1.overflow);
      oc = 32'(bus1.ocupado); rd = 32'(bus1.item_ready);
    end
  endtask

  task automatic compare_all();
    int sf, sp, n, vt, em, ov, oc, rd;
    for (int i = 0; i < 2; i++) begin
      read_dut(i, sf, sp, n, vt, em, ov, oc, rd);
      check($sformatf("u%0d.soma_final", i), sf, m_sp[i]);
      check($sformatf("u%0d.soma_peso", i), sp, m_sw[i]);
      check($sformatf("u%0d.n_itens", i), n, m_n[i]);
      check($sformatf("u%0d.valor_taxa", i), vt, m_fee[i]);
      check($sformatf("u%0d.emissao_talao", i), em, (m_ph[i] == 2) ? 1 : 0);
      check($sformatf("u%0d.overflow", i), ov, m_ovf[i]);
      check($sformatf("u%0d.ocupado", i), oc, (m_ph[i] != 0) ? 1 : 0);
    end
  endtask

  task automatic drive(input int iv, input int pp, input int pw, input int est,
                       input int tx, input int fim, input int tr);
    bus0.item_valid = iv[0]; bus0.preco_produto = pp[10:0]; bus0.peso_produto = pw[10:0];
    bus0.estorno = est[0]; bus0.taxa = tx[0]; bus0.fim_compra = fim[0]; bus0.talao_ready = tr[0];
    bus1.item_valid = iv[0]; bus1.preco_produto = pp[10:0]; bus1.peso_produto = pw[10:0];
    bus1.estorno = est[0]; bus1.taxa = tx[0]; bus1.fim_compra = fim[0]; bus1.talao_ready = tr[0];
  endtask

  // One clock of stimulus, starting and ending at a falling edge.
  task automatic step(input int iv, input int pp, input int pw, input int est,
                      input int tx, input int fim, input int tr);
    int sf, sp, n, vt, em, ov, oc, rd;
    drive(iv, pp, pw, est, tx, fim, tr);
    #1;
    for (int i = 0; i < 2; i++) begin
      read_dut(i, sf, sp, n, vt, em, ov, oc, rd);
      last_rdy[i] = rd;
      check($sformatf("u%0d.item_ready", i), rd, m_ready(i, est));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, iv, pp, pw, est, tx, fim, tr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic item(input int pp, input int pw); step(1, pp, pw, 0, 0, 0, 0); endtask
  task automatic idle(input int tr);                step(0, 0, 0, 0, 0, 0, tr); endtask
  task automatic void_last();                       step(0, 0, 0, 1, 0, 0, 0); endtask
  task automatic fim();                             step(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic close_purchase();
    fim(); idle(0); idle(1);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset soma_final", 32'(bus0.soma_final), 0);
    rst = 1'b0;

    // Four items, no fee; receipt appears two cycles after fim_compra.
    repeat (4) item(250, 500);
    fim();
    check("latency emissao +1", 32'(bus0.emissao_talao), 0);
    idle(0);
    check("latency emissao +2", 32'(bus0.emissao_talao), 1);
    check("t1 soma_final", 32'(bus0.soma_final), 1000);
    check("t1 soma_peso", 32'(bus0.soma_peso), 2000);
    check("t1 n_itens", 32'(bus0.n_itens), 4);
    check("t1 valor_taxa", 32'(bus0.valor_taxa), 0);
    idle(1);
    check("t1 emissao drop", 32'(bus0.emissao_talao), 0);

    // Same items with a single taxa pulse.
    step(1, 250, 500, 0, 1, 0, 0);
    repeat (3) item(250, 500);
    fim(); idle(0);
    check("t2 soma_final", 32'(bus0.soma_final), 1005);
    check("t2 valor_taxa", 32'(bus0.valor_taxa), 5);
    idle(1);
    check("t2 clr soma_final", 32'(bus0.soma_final), 0);
    check("t2 clr soma_peso", 32'(bus0.soma_peso), 0);
    check("t2 clr n_itens", 32'(bus0.n_itens), 0);
    check("t2 clr valor_taxa", 32'(bus0.valor_taxa), 0);
    check("t2 clr ocupado", 32'(bus0.ocupado), 0);

    // One-level void, and estorno beating a simultaneous item.
    item(250, 500); item(100, 300);
    void_last();
    check("t3 void soma_final", 32'(bus0.soma_final), 250);
    check("t3 void soma_peso", 32'(bus0.soma_peso), 500);
    check("t3 void n_itens", 32'(bus0.n_itens), 1);
    void_last();
    check("t3 2nd void n_itens", 32'(bus0.n_itens), 1);
    check("t3 2nd void soma_final", 32'(bus0.soma_final), 250);
    step(1, 7, 7, 1, 0, 0, 0);
    check("t3 estorno+item ready", last_rdy[0], 0);
    check("t3 estorno+item soma", 32'(bus0.soma_final), 250);
    close_purchase();

    // Saturation on the 12-bit instance; void refused there afterwards.
    repeat (3) item(2047, 2047);
    check("t4 u1 soma_final", 32'(bus1.soma_final), 4095);
    check("t4 u1 overflow", 32'(bus1.overflow), 1);
    check("t4 u0 soma_final", 32'(bus0.soma_final), 6141);
    check("t4 u0 overflow", 32'(bus0.overflow), 0);
    void_last();
    check("t4 u1 void ignored n", 32'(bus1.n_itens), 3);
    check("t4 u1 void ignored sum", 32'(bus1.soma_final), 4095);
    check("t4 u0 void n", 32'(bus0.n_itens), 2);
    close_purchase();

    // Empty fim_compra ignored; receipt held while talao_ready stays low.
    fim();
    check("t5 empty fim ocupado", 32'(bus0.ocupado), 0);
    idle(0);
    check("t5 empty fim emissao", 32'(bus0.emissao_talao), 0);
    item(10, 20); fim(); idle(0);
    for (int k = 0; k < 3; k++) begin
      step(1, 5, 5, 0, 0, 0, 0);
      check("t5 hold ready", last_rdy[0], 0);
      check("t5 hold soma_final", 32'(bus0.soma_final), 10);
      check("t5 hold emissao", 32'(bus0.emissao_talao), 1);
    end
    idle(1);

    // Asynchronous reset in the middle of a receipt.
    item(30, 40); fim(); idle(0);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("t6 rst emissao", 32'(bus0.emissao_talao), 0);
    check("t6 rst soma_final", 32'(bus0.soma_final), 0);
    @(negedge clk);
    rst = 1'b0;
    item(9, 8);
    check("t6 clean soma_final", 32'(bus0.soma_final), 9);
    check("t6 clean n_itens", 32'(bus0.n_itens), 1);
    close_purchase();

    // Item-count ceiling.
    repeat (256) item(1, 1);
    check("t7 max n_itens", 32'(bus0.n_itens), 255);
    check("t7 max ready", last_rdy[0], 0);
    check("t7 max soma_final", 32'(bus0.soma_final), 255);
    close_purchase();

    // Randomised traffic.
    repeat (3000) begin
      step(($urandom_range(0, 9) < 6) ? 1 : 0, $urandom_range(0, 2047), $urandom_range(0, 2047),
           ($urandom_range(0, 9) == 0) ? 1 : 0, ($urandom_range(0, 19) == 0) ? 1 : 0,
           ($urandom_range(0, 19) == 0) ? 1 : 0, $urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
